// File: rtl/gate_tt_checker.sv
// gate_tt_checker: exhaustive truth-table checker for an external 2-input gate.
// Walks the four input vectors 00,01,10,11 on dut_a/dut_b. After each vector it
// waits a programmable number of settle cycles, then samples dut_y and compares
// it with the gate function selected at start.
//
// Ports:
//   clk, rst_n        - clock; synchronous active-low reset
//   start             - run request, only looked at while idle
//   func_sel[2:0]     - expected function: AND,OR,XOR,NAND,NOR,XNOR,A,NOT A
//   settle[SETTLE_W-1:0] - wait cycles between applying a vector and sampling
//   dut_a, dut_b      - registered stimulus to the gate under test
//   dut_y             - gate response
//   busy              - run in progress (APPLY/WAIT/SAMPLE)
//   done              - one-cycle pulse when the results are published
//   pass, mismatch_map[3:0], err_count[2:0] - results of the last run
module gate_tt_checker #(
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          func_sel,
  input  logic [SETTLE_W-1:0] settle,
  output logic                dut_a,
  output logic                dut_b,
  input  logic                dut_y,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [3:0]          mismatch_map,
  output logic [2:0]          err_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [2:0]          func_q, func_d;
  logic                a_q, a_d, b_q, b_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [3:0]          map_q, map_d;
  logic [2:0]          err_q, err_d;
  logic                exp_y;

  // Expected gate output for the vector currently on the pins.
  always_comb begin
    exp_y = 1'b0;
    case (func_q)
      3'b000:  exp_y =   a_q & b_q;
      3'b001:  exp_y =   a_q | b_q;
      3'b010:  exp_y =   a_q ^ b_q;
      3'b011:  exp_y = ~(a_q & b_q);
      3'b100:  exp_y = ~(a_q | b_q);
      3'b101:  exp_y = ~(a_q ^ b_q);
      3'b110:  exp_y =   a_q;
      default: exp_y =  ~a_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    func_d   = func_q;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    map_d    = map_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_APPLY;
          idx_d    = 2'd0;
          map_d    = 4'd0;
          err_d    = 3'd0;
          pass_d   = 1'b0;
          func_d   = func_sel;
          settle_d = settle;
        end
      end
      S_APPLY: begin
        a_d     = idx_q[1];
        b_d     = idx_q[0];
        cnt_d   = settle_q;
        state_d = (settle_q != '0) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        // Leave on the cycle the counter reads 1: exactly settle WAIT cycles,
        // and a full-scale settle value counts down without wrapping.
        cnt_d = cnt_q - SETTLE_W'(1);
        if (cnt_q <= SETTLE_W'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (dut_y != exp_y) begin
          map_d[idx_q] = 1'b1;
          if (err_q < 3'd4) err_d = err_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        // err_q already includes the final SAMPLE's result here.
        done_d  = 1'b1;
        pass_d  = (err_q == 3'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      settle_q <= '0;
      func_q   <= 3'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      map_q    <= 4'd0;
      err_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      func_q   <= func_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      map_q    <= map_d;
      err_q    <= err_d;
    end
  end

  assign dut_a        = a_q;
  assign dut_b        = b_q;
  assign busy         = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_map = map_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Randomized scoreboard bench for gate_tt_checker. A behavioural gate (truth
// table lookup) answers dut_y; each run pushes its predicted result, and an
// independent monitor pops and checks whenever done pulses.
module tb_gate_tt_checker;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    func_sel = 3'd0;
  logic [SW-1:0] settle = '0;
  logic          dut_a, dut_b, dut_y, busy, done, pass;
  logic [3:0]    mismatch_map;
  logic [2:0]    err_count;
  int            gate_mode = 0;

  gate_tt_checker #(.SETTLE_W(SW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .settle(settle), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .mismatch_map(mismatch_map),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Truth table per function, bit index {a,b}. Modes 8/9 model a stuck output.
  function automatic bit tt(input int f, input bit a, input bit b);
    bit [3:0] t;
    case (f)
      0: t = 4'b1000; 1: t = 4'b1110; 2: t = 4'b0110; 3: t = 4'b0111;
      4: t = 4'b0001; 5: t = 4'b1001; 6: t = 4'b1100; 7: t = 4'b0011;
      8: t = 4'b1111; default: t = 4'b0000;
    endcase
    return t[{a, b}];
  endfunction

  always_comb dut_y = tt(gate_mode, dut_a, dut_b);

  typedef struct {
    logic [3:0] map;
    int         err;
    bit         pas;
    int         lat;
    int         start_cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: result checks on done, stability checks while idle.
  exp_t mon_e, last_e;
  bit   have_last = 0;
  bit   prev_done = 0;
  always @(negedge clk) begin
    if (!rst_n || busy) begin
      have_last = 0;
    end else if (done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("mismatch_map", {28'd0, mismatch_map}, {28'd0, mon_e.map});
        chk("err_count", {29'd0, err_count}, mon_e.err);
        chk("pass", {31'd0, pass}, {31'd0, mon_e.pas});
        chk("done_latency", cyc - mon_e.start_cyc, mon_e.lat);
        last_e    = mon_e;
        have_last = 1;
      end
      done_seen++;
    end else if (have_last) begin
      chk("result_hold", {pass, err_count, mismatch_map},
          {last_e.pas, 3'(last_e.err), last_e.map});
    end
    prev_done = done;
  end

  // One run. glitch_k: cycle at which start is re-pulsed with XOR selected.
  // abort_k: cycle at which reset is asserted (with start also high).
  task automatic run(input int fs, input int st, input int gm,
                     input int glitch_k, input int abort_k);
    exp_t e;
    int   per, total, seen0;
    bit   vec_ok, busy_ok, finished;
    per   = st + 2;
    total = 4 * per;
    e.map = 4'd0;
    e.err = 0;
    for (int v = 0; v < 4; v++) begin
      bit a, b;
      a = bit'((v >> 1) & 1);
      b = bit'(v & 1);
      if (tt(gm, a, b) != tt(fs, a, b)) begin
        e.map[v] = 1'b1;
        e.err++;
      end
    end
    e.pas = (e.err == 0);
    e.lat = total + 1;
    @(negedge clk);
    gate_mode   = gm;
    func_sel    = 3'(fs);
    settle      = SW'(st);
    start       = 1'b1;
    e.start_cyc = cyc + 1;
    q.push_back(e);
    seen0    = done_seen;
    vec_ok   = 1;
    busy_ok  = 1;
    finished = 0;
    for (int k = 0; k <= total + 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        start    = 1'b0;
        func_sel = 3'($urandom);
        settle   = SW'($urandom);
      end
      if (k == abort_k + 1 && abort_k >= 0) begin
        void'(q.pop_back());
        chk("abort_outputs", {25'd0, busy, done, pass, mismatch_map, err_count, dut_a, dut_b}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      if (k < total && busy !== 1'b1) busy_ok = 0;
      if (k == total && busy !== 1'b0) busy_ok = 0;
      if (k >= 1 && k <= total && {dut_a, dut_b} !== 2'((k - 1) / per)) vec_ok = 0;
      if (k == glitch_k) begin
        start    = 1'b1;
        func_sel = 3'b010;
        settle   = SW'($urandom);
      end
      if (k == glitch_k + 1 && glitch_k >= 0) start = 1'b0;
      if (k == abort_k) begin
        rst_n    = 1'b0;
        start    = 1'b1;
        func_sel = 3'($urandom);
      end
      if (done_seen != seen0) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", {31'd0, finished}, 32'd1);
    chk("vector_sequence", {31'd0, vec_ok}, 32'd1);
    chk("busy_profile", {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;  // reset must win over start
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {25'd0, busy, done, pass, mismatch_map, err_count, dut_a, dut_b}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    run(0, 0, 0, -1, -1);          // AND gate, AND expected, settle 0
    run(1, 0, 0, -1, -1);          // AND gate, OR expected -> 0110
    run(3, 3, 8, -1, -1);          // tied high, NAND expected -> 1000
    run(0, 2, 0, 5, -1);           // start re-pulsed mid-run with XOR
    run(4, 1, 4, 12, -1);          // start pulsed in DONE
    run(5, 1, 2, -1, 2 * 3 + 2);   // reset during vector 2
    run(0, 0, 0, -1, -1);          // immediately after reset release
    run(6, 15, 6, -1, -1);         // maximum settle
    run(7, 15, 1, -1, -1);

    for (int i = 0; i < 25; i++) begin
      int fs, st, gm, gk;
      fs = int'($urandom_range(7, 0));
      st = int'($urandom_range(15, 0));
      gm = int'($urandom_range(9, 0));
      gk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4 * (st + 2), 1)) : -1;
      run(fs, st, gm, gk, -1);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
Parameters:
REQ-001 SHALL have parameter SETTLE_W, default 4, giving the width of the settle-cycle field.

Ports:
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-005 SHALL have port func_sel, input, 3, expected gate function; latched on accepted start. Encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 A, 111 NOT A.
REQ-006 SHALL have port settle, input, SETTLE_W, number of wait cycles per vector; latched on accepted start.
REQ-007 SHALL have port dut_a, output, 1, registered stimulus to the gate under test.
REQ-008 SHALL have port dut_b, output, 1, registered stimulus to the gate under test.
REQ-009 SHALL have port dut_y, input, 1, response of the gate under test.
REQ-010 SHALL have port busy, output, 1, high in APPLY, WAIT and SAMPLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at end of run.
REQ-012 SHALL have port pass, output, 1, 1 when the last run had zero mismatches.
REQ-013 SHALL have port mismatch_map, output, 4, bit i set when vector i mismatched.
REQ-014 SHALL have port err_count, output, 3, mismatch count of the last run (0..4).

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, WAIT, SAMPLE and DONE.
REQ-016 SHALL leave IDLE for APPLY when start=1; on that edge it clears idx, mismatch_map, err_count and pass, and latches func_sel and settle.
REQ-017 SHALL use vector index idx from 0 to 3, with dut_a=idx[1] and dut_b=idx[0], giving order 00, 01, 10, 11.
REQ-018 SHALL, in APPLY, drive the vector for idx and load the settle counter with the latched settle value, then go to WAIT if settle!=0, else to SAMPLE.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and go to SAMPLE on the cycle the counter reaches 1 (exactly settle WAIT cycles).
REQ-020 SHALL, in SAMPLE, compare dut_y with the expected value f(dut_a,dut_b); on mismatch it sets mismatch_map[idx] and increments err_count.
REQ-021 SHALL, after SAMPLE, go to DONE if idx==3, else increment idx and go to APPLY.
REQ-022 SHALL, in DONE, assert done for exactly one cycle, set pass=(err_count==0) including any mismatch from the final SAMPLE, then return to IDLE.
REQ-023 SHALL hold dut_a/dut_b at their last values in DONE and IDLE until the next run.
REQ-024 SHALL hold pass, mismatch_map and err_count stable from DONE until the next accepted start.
REQ-025 SHALL ignore start while busy=1 or in DONE, with no restart and no change to latched settings.
REQ-026 SHALL place done at cycle 4*(settle+2)+1 after the start edge (settle=0 gives 9; settle=15 gives 69).
REQ-027 SHALL use a settle counter exactly SETTLE_W bits wide; the maximum value must not wrap to an early exit.
REQ-028 SHALL never let err_count exceed 4, so it does not overflow.

Reset
REQ-029 SHALL, on a clk edge with rst_n=0, go to IDLE with dut_a=0, dut_b=0, busy=0, done=0, pass=0, mismatch_map=0000, err_count=0, idx=0 and counter=0.
REQ-030 SHALL, on reset mid-run, abort immediately with no done pulse, discard partial results, and accept start on the first cycle after rst_n returns to 1.
REQ-031 SHALL give reset priority over start in the same cycle.

Verification
REQ-032 SHALL be verified with: dut_y=dut_a&dut_b, func_sel=000, settle=0 -> done at cycle 9, pass=1, mismatch_map=0000, err_count=0.
REQ-033 SHALL be verified with: same AND connection, func_sel=001 (OR) -> mismatch_map=0110, err_count=2, pass=0.
REQ-034 SHALL be verified with: dut_y tied to 1, func_sel=011 (NAND), settle=3 -> done at cycle 21, mismatch_map=1000, err_count=1; dut_a/dut_b follow 00, 01, 10, 11, each held 5 cycles.
REQ-035 SHALL be verified with: start pulsed again mid-run with func_sel=010 -> ignored; result matches the original func_sel and exactly one done pulse.
REQ-036 SHALL be verified with: rst_n=0 for 1 cycle during vector 2 -> all outputs at reset values, no done; a new start then completes normally.
REQ-037 SHALL be verified with: settle=15 (max) -> each vector held 17 cycles, done at cycle 69, no early SAMPLE.
